uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one 8-bit UART transmitter between NUM_REQ requesters using round-robin arbitration.
- Accepts one byte per handshake from a requester and issues a single-cycle start strobe plus stable data to the transmitter.
- Holds off further grants until the transmitter reports frame completion.
- Sits between the command/debug sources and the single UART TX pin driver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match the transmitter data input.
- TIMEOUT_CYCLES, 256, watchdog limit in clk cycles for one frame; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req_valid_i  input  NUM_REQ  per-requester byte-pending flag; held until accepted.
- req_data_i  input  NUM_REQ*DATA_W  packed bytes; requester k occupies bits [k*DATA_W +: DATA_W].
- req_ready_o  output  NUM_REQ  one-cycle accept pulse, one-hot.
- tx_en_o  output  1  one-cycle start strobe to the transmitter.
- tx_data_o  output  DATA_W  byte presented to the transmitter.
- tx_done_i  input  1  one-cycle frame-complete pulse from the transmitter.
- busy_o  output  1  high while a frame is in flight.
- grant_id_o  output  $clog2(NUM_REQ)  index of the last granted requester.
- timeout_o  output  1  one-cycle watchdog pulse; tied 0 when the feature is compiled out.

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - req_ready_o=0, tx_en_o=0, tx_data_o=0, busy_o=0, grant_id_o=0, timeout_o=0.
  - State=S_IDLE; round-robin pointer=0, so requester 0 has top priority after reset.
- State encoding: one-hot. States are S_IDLE, S_ISSUE, S_WAIT.
- S_IDLE:
  - If any req_valid_i bit is set, the winner is the first set bit scanning upward from the pointer, wrapping at NUM_REQ-1.
  - At that edge: tx_data_o <= winner's byte; grant_id_o <= winner; req_ready_o[winner] <= 1; tx_en_o <= 1; busy_o <= 1; pointer <= winner+1 (mod NUM_REQ); next state S_ISSUE.
  - If no bit is set, remain in S_IDLE with all strobes 0.
- S_ISSUE (exactly one cycle):
  - req_ready_o and tx_en_o are high during this cycle only; cleared at the exiting edge.
  - Next state S_WAIT.
  - tx_data_o stays stable from S_ISSUE until the next grant, because the transmitter resamples data every idle cycle.
- S_WAIT:
  - On tx_done_i=1: busy_o <= 0, next state S_IDLE.
  - Otherwise remain in S_WAIT.
  - Minimum spacing between tx_en_o pulses is 3 cycles plus frame time.
  - tx_en_o is never held high: a level strobe would retrigger the transmitter.
- Latency: req_valid_i seen in S_IDLE → req_ready_o and tx_en_o high the next cycle.
- Handshake rules:
  - A requester must keep req_valid_i and its byte stable until it sees its req_ready_o.
  - A requester may drop req_valid_i before acceptance; no byte is sent and no error is raised.
  - A new req_valid_i asserted during S_ISSUE or S_WAIT waits for S_IDLE.
- Boundary conditions:
  - tx_done_i in S_IDLE or S_ISSUE: ignored (spurious).
  - All requesters valid: grants strictly rotate 0,1,2,3,0,...
  - Single requester continuously valid: granted back-to-back, one per frame.
  - Pointer wraps from NUM_REQ-1 to 0.
  - rst mid-frame: arbiter returns to reset values next edge. The transmitter reset is driven from the same source, inverted, at integration.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to S_WAIT and increments each S_WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 without tx_done_i: timeout_o <= 1 for one cycle, busy_o <= 0, next state S_IDLE.
  - The pointer is not rewound, so the faulty byte is dropped.
  - tx_done_i in the same cycle as expiry wins: no timeout pulse.
- Undefined: no counter is built; timeout_o is constant 0; S_WAIT waits indefinitely.

Decomposition:
- Package uart_pkg: DATA_W default, one-hot state localparams (S_IDLE, S_ISSUE, S_WAIT), simulation TIMEOUT_CYCLES default.
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded index, any_req.
  - Pointer register stays in uart_tx_arbiter.

Test Plan:
- Reset then idle, no requests → all outputs 0 and no tx_en_o for 50 cycles; rst mid-S_WAIT → busy_o=0 and state S_IDLE next edge.
- req_valid_i=0001, byte 0x55 → req_ready_o=0001 and tx_en_o=1 on the same cycle, one cycle after request; tx_data_o=0x55 stable until tx_done_i; busy_o clears the cycle after done.
- req_valid_i=1111 continuously, bytes 0xA0..0xA3 → grant order 0,1,2,3,0; tx_data_o sequence A0,A1,A2,A3,A0; exactly one tx_en_o per tx_done_i.
- Request on index 2 arrives during S_WAIT of index 0 → not accepted until after tx_done_i; then granted with grant_id_o=2.
- tx_done_i pulsed in S_IDLE, and req_valid_i withdrawn before grant → no state change, no tx_en_o.
- With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, tx_done_i never asserted → timeout_o pulses after 16 S_WAIT cycles, then the next pending requester is granted; a done pulse on cycle 16 gives no timeout_o.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and one-hot state encoding for the UART TX arbiter.
package uart_pkg;
  localparam int DATA_W_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF = 256;
  localparam int TIMEOUT_CYCLES_SIM = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_ISSUE = 3'b010,
    S_WAIT  = 3'b100
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above ptr, wrapping at NUM_REQ-1.
// Zero latency; the caller owns the pointer register and decides when a pick is consumed.
module rr_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  // Distance of requester i from the pointer, walking upward with wrap.
  function automatic int dist_from_ptr(input int i, input int p);
    return (i >= p) ? (i - p) : (i + NUM_REQ - p);
  endfunction

  int best_dist;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_req   = 1'b0;
    best_dist = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (dist_from_ptr(i, int'(ptr)) < best_dist)) begin
        best_dist = dist_from_ptr(i, int'(ptr));
        grant     = '0;
        grant[i]  = 1'b1;
        idx       = IDX_W'(i);
        any_req   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter: grant one cycle after a request seen in idle, then block until tx_done_i.
// Requesters hold valid until their one-cycle ready pulse; optional watchdog under UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic                         tx_en_o,
  output logic [DATA_W-1:0]            tx_data_o,
  input  logic                         tx_done_i,
  output logic                         busy_o,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id_o,
  output logic                         timeout_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("uart_tx_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [DATA_W-1:0]  win_byte;
  logic               any_req;
  logic               take;
  logic               frame_end;
  logic               expire;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid_i),
    .ptr     (ptr),
    .grant   (win_onehot),
    .idx     (win_idx),
    .any_req (any_req)
  );

  always_comb begin
    win_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_onehot[k]) win_byte = req_data_i[k*DATA_W +: DATA_W];
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  // Held at zero outside S_WAIT, so every frame starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end

  assign expire = (state == S_WAIT) && !tx_done_i &&
                  (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= expire;
  end

  assign timeout_o = timeout_q;
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    frame_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          take      = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (tx_done_i || expire) begin
          frame_end = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // tx_data_o is only reloaded on a grant: the transmitter resamples it while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      req_ready_o <= '0;
      tx_en_o     <= 1'b0;
      tx_data_o   <= '0;
      busy_o      <= 1'b0;
      grant_id_o  <= '0;
    end else begin
      req_ready_o <= take ? win_onehot : '0;
      tx_en_o     <= take;
      if (take) begin
        tx_data_o  <= win_byte;
        grant_id_o <= win_idx;
        busy_o     <= 1'b1;
        ptr        <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else if (frame_end) begin
        busy_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences, random traffic vs. a reference model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam int TO = 16;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic           tx_done   = 1'b0;
  logic [N-1:0]   req_ready;
  logic           tx_en;
  logic [W-1:0]   tx_data;
  logic           busy;
  logic [IW-1:0]  grant_id;
  logic           timeout;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .tx_en_o     (tx_en),
    .tx_data_o   (tx_data),
    .tx_done_i   (tx_done),
    .busy_o      (busy),
    .grant_id_o  (grant_id),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int fails    = 0;
  int en_count = 0;
  int cyc      = 0;

  // Reference model: phase 0 = free, 1 = strobe cycle, 2 = frame on the wire.
  int            m_phase = 0;
  int            m_ptr   = 0;
  int            m_waited = 0;
  logic [N-1:0]  m_ready = '0;
  logic          m_en    = 1'b0;
  logic [W-1:0]  m_data  = '0;
  logic          m_busy  = 1'b0;
  logic [IW-1:0] m_id    = '0;
  logic          m_to    = 1'b0;

  task automatic model_edge();
    m_ready = '0;
    m_en    = 1'b0;
    m_to    = 1'b0;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_data = '0; m_busy = 1'b0; m_id = '0;
    end else if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!m_en && req_valid[c]) begin
          m_en = 1'b1; m_ready[c] = 1'b1; m_data = req_data[c*W +: W];
          m_id = IW'(c); m_busy = 1'b1; m_ptr = (c + 1) % N; m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      m_phase = 2; m_waited = 0;
    end else begin
      m_waited++;
      if (tx_done) begin
        m_busy = 1'b0; m_phase = 0;
      end
`ifdef UART_ARB_TIMEOUT_EN
      else if (m_waited == TO) begin
        m_busy = 1'b0; m_phase = 0; m_to = 1'b1;
      end
`endif
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    if (tx_en) en_count++;
  endtask

  task automatic check(input string name, input logic [N-1:0] er, input logic ee,
                       input logic [W-1:0] ed, input logic eb, input logic [IW-1:0] ei,
                       input logic eto);
    checks++;
    if ({req_ready, tx_en, tx_data, busy, grant_id, timeout} !== {er, ee, ed, eb, ei, eto}) begin
      fails++;
      $display("FAIL %s @%0d: got rdy=%b en=%b dat=%h busy=%b id=%0d to=%b, want rdy=%b en=%b dat=%h busy=%b id=%0d to=%b",
               name, cyc, req_ready, tx_en, tx_data, busy, grant_id, timeout, er, ee, ed, eb, ei, eto);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_ready, m_en, m_data, m_busy, m_id, m_to);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s @%0d: got %0d, want %0d", name, cyc, got, want);
    end
  endtask

  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      ok = tx_en;
    end
  endtask

  typedef struct {
    logic           r;
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic           dn;
    logic [N-1:0]   rdy;
    logic           en;
    logic [W-1:0]   dat;
    logic           b;
    logic [IW-1:0]  id;
  } vec_t;

  function automatic vec_t mk(logic r, logic [N-1:0] v, logic [N*W-1:0] d, logic dn,
                              logic [N-1:0] rdy, logic en, logic [W-1:0] dat, logic b,
                              logic [IW-1:0] id);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.dn = dn; x.rdy = rdy; x.en = en; x.dat = dat; x.b = b; x.id = id;
    return x;
  endfunction

  vec_t tbl[24];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int last_en;

    tbl[0]  = mk(1, 4'h0, 32'h00000000, 0, 4'h0, 0, 8'h00, 0, 0);
    tbl[1]  = mk(0, 4'h0, 32'h00000000, 0, 4'h0, 0, 8'h00, 0, 0);
    tbl[2]  = mk(0, 4'h1, 32'h00000055, 0, 4'h1, 1, 8'h55, 1, 0);
    tbl[3]  = mk(0, 4'h0, 32'h00000000, 0, 4'h0, 0, 8'h55, 1, 0);
    tbl[4]  = mk(0, 4'h0, 32'h00000000, 0, 4'h0, 0, 8'h55, 1, 0);
    tbl[5]  = mk(0, 4'h0, 32'h00000000, 1, 4'h0, 0, 8'h55, 0, 0);
    tbl[6]  = mk(0, 4'h0, 32'h00000000, 1, 4'h0, 0, 8'h55, 0, 0);
    tbl[7]  = mk(0, 4'h4, 32'h00770000, 0, 4'h4, 1, 8'h77, 1, 2);
    tbl[8]  = mk(0, 4'h0, 32'h00000000, 1, 4'h0, 0, 8'h77, 1, 2);
    tbl[9]  = mk(0, 4'h8, 32'h99000000, 0, 4'h0, 0, 8'h77, 1, 2);
    tbl[10] = mk(0, 4'h0, 32'h00000000, 0, 4'h0, 0, 8'h77, 1, 2);
    tbl[11] = mk(0, 4'h0, 32'h00000000, 1, 4'h0, 0, 8'h77, 0, 2);
    tbl[12] = mk(0, 4'h0, 32'h00000000, 0, 4'h0, 0, 8'h77, 0, 2);
    tbl[13] = mk(0, 4'h1, 32'h00000011, 0, 4'h1, 1, 8'h11, 1, 0);
    tbl[14] = mk(0, 4'h0, 32'h00000000, 0, 4'h0, 0, 8'h11, 1, 0);
    tbl[15] = mk(0, 4'h2, 32'h00002200, 0, 4'h0, 0, 8'h11, 1, 0);
    tbl[16] = mk(0, 4'h2, 32'h00002200, 1, 4'h0, 0, 8'h11, 0, 0);
    tbl[17] = mk(0, 4'h2, 32'h00002200, 0, 4'h2, 1, 8'h22, 1, 1);
    tbl[18] = mk(0, 4'h0, 32'h00000000, 0, 4'h0, 0, 8'h22, 1, 1);
    tbl[19] = mk(1, 4'h0, 32'h00000000, 0, 4'h0, 0, 8'h00, 0, 0);
    tbl[20] = mk(0, 4'h6, 32'h00332200, 0, 4'h2, 1, 8'h22, 1, 1);
    tbl[21] = mk(0, 4'h4, 32'h00332200, 0, 4'h0, 0, 8'h22, 1, 1);
    tbl[22] = mk(0, 4'h4, 32'h00332200, 1, 4'h0, 0, 8'h22, 0, 1);
    tbl[23] = mk(0, 4'h4, 32'h00332200, 0, 4'h4, 1, 8'h33, 1, 2);

    // Reset, then 50 quiet cycles.
    rst = 1'b1;
    tick();
    check("reset", '0, 1'b0, '0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    en_count = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle", '0, 1'b0, '0, 1'b0, '0, 1'b0);
    end
    check_int("idle_no_tx_en", en_count, 0);

    for (int i = 0; i < 24; i++) begin
      rst = tbl[i].r; req_valid = tbl[i].v; req_data = tbl[i].d; tx_done = tbl[i].dn;
      tick();
      check($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].en, tbl[i].dat, tbl[i].b, tbl[i].id, 1'b0);
    end

    // Close the open frame and restart with the pointer at 0.
    req_valid = '0; tx_done = 1'b0; tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;

    // All requesters valid: strict rotation, one strobe per completed frame.
    req_data = 32'hA3A2A1A0;
    req_valid = '1;
    en_count = 0;
    for (int g = 0; g < 5; g++) begin
      logic [W-1:0] b;
      b = W'(8'hA0 + g % 4);
      tick();
      check("rot_grant", N'(1) << (g % 4), 1'b1, b, 1'b1, IW'(g % 4), 1'b0);
      tick();
      check("rot_wait", '0, 1'b0, b, 1'b1, IW'(g % 4), 1'b0);
      tick();
      tx_done = 1'b1; tick(); tx_done = 1'b0;
      check("rot_done", '0, 1'b0, b, 1'b0, IW'(g % 4), 1'b0);
    end
    check_int("rot_en_per_done", en_count, 5);

    // Single requester held valid: back-to-back frames, spacing 3 + extra wait cycles.
    req_valid = 4'b0001;
    req_data  = 32'h0000005A;
    last_en = 0;
    for (int f = 0; f < 3; f++) begin
      wait_en(ok);
      check_int("b2b_en_seen", int'(ok), 1);
      check("b2b_grant", 4'b0001, 1'b1, 8'h5A, 1'b1, 2'd0, 1'b0);
      if (f > 0) check_int("b2b_spacing", cyc - last_en, 3 + (f - 1));
      last_en = cyc;
      tick();
      repeat (f) tick();
      tx_done = 1'b1; tick(); tx_done = 1'b0;
    end
    req_valid = '0;
    tick();
    check_model("b2b_release");

`ifdef UART_ARB_TIMEOUT_EN
    req_valid = 4'b0010; req_data = 32'h00006B00;
    tick();
    check("to_grant", 4'b0010, 1'b1, 8'h6B, 1'b1, 2'd1, 1'b0);
    req_valid = 4'b0001; req_data = 32'h00006B3C;
    tick();
    for (int i = 1; i < TO; i++) begin
      tick();
      check("to_quiet", '0, 1'b0, 8'h6B, 1'b1, 2'd1, 1'b0);
    end
    tick();
    check("to_pulse", '0, 1'b0, 8'h6B, 1'b0, 2'd1, 1'b1);
    tick();
    check("to_next_grant", 4'b0001, 1'b1, 8'h3C, 1'b1, 2'd0, 1'b0);
    req_valid = '0;
    tick();
    repeat (TO - 1) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("to_done_wins", '0, 1'b0, 8'h3C, 1'b0, 2'd0, 1'b0);
    tick();
    check("to_after_done", '0, 1'b0, 8'h3C, 1'b0, 2'd0, 1'b0);
`endif

    // Random traffic against the reference model.
    rst = 1'b1; req_valid = '0; tick(); rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < N; k++) begin
        if (req_valid[k] && m_ready[k]) req_valid[k] = 1'b0;
        else if (req_valid[k] && $urandom_range(0, 15) == 0) req_valid[k] = 1'b0;
        else if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
          req_valid[k] = 1'b1;
          req_data[k*W +: W] = W'($urandom);
        end
      end
      tx_done = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      check_model("rand");
    end
    rst = 1'b0; tx_done = 1'b0; req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
